fifo_write_arbiter: RTL

Round-robin write-port arbiter that shares the single 32-bit push interface of the 32-deep FIFO among several producers. Each producer offers words through a valid/ready handshake. The arbiter grants one producer at a time for a bounded burst and drives the FIFO's `w_en`/`data_in`. It honours `full`, so no word is ever lost or duplicated. It sits directly in front of the FIFO; the FIFO's read side is untouched.

---
 rtl/fifo_write_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_write_arbiter
//  Description : Round-robin arbiter sharing one FIFO push port among NREQ
//                valid/ready producers, with bounded bursts per grant.
//                Optional per-producer accept counters: FIFO_ARB_STATS_EN.
//  Revision    : 1.0
// ============================================================================
module fifo_write_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 32,
    parameter int BURST_MAX = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*DW-1:0]      req_data,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    fifo_full,
    output logic                    fifo_w_en,
    output logic [DW-1:0]           fifo_data_in,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    busy
`ifdef FIFO_ARB_STATS_EN
    ,
    input  logic [$clog2(NREQ)-1:0] stat_sel,
    output logic [15:0]             stat_count
`endif
);

    localparam int c_IW = $clog2(NREQ);
    localparam int c_BW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
    localparam logic [c_BW-1:0] c_LAST_BEAT = c_BW'(BURST_MAX - 1);
    localparam logic [c_IW-1:0] c_LAST_IDX  = c_IW'(NREQ - 1);

    localparam logic [0:0] c_S_IDLE  = 1'b0;
    localparam logic [0:0] c_S_BURST = 1'b1;

    logic [0:0]      r_state,    w_state_nxt;
    logic [c_IW-1:0] r_owner,    w_owner_nxt;
    logic [c_IW-1:0] r_rr_ptr,   w_rr_nxt;
    logic [c_BW-1:0] r_beat_cnt, w_beat_nxt;

    logic [DW-1:0]   w_lane [NREQ];
    logic            w_xfer;
    logic            w_burst_end;
    logic [c_IW-1:0] w_next_base;

    // First requester at or after base, wrapping; base itself wins ties.
    function automatic logic [c_IW-1:0] rr_pick(input logic [c_IW-1:0] base,
                                                 input logic [NREQ-1:0] valid);
        logic [c_IW-1:0] sel;
        int              idx;
        sel = base;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(base) + k) % NREQ;
            if (valid[c_IW'(idx)]) sel = c_IW'(idx);
        end
        return sel;
    endfunction

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        assign w_lane[i] = req_data[i*DW +: DW];
    end

    assign w_xfer      = (r_state == c_S_BURST) && req_valid[r_owner] && !fifo_full;
    assign w_burst_end = (r_state == c_S_BURST) &&
                         ((w_xfer && (r_beat_cnt == c_LAST_BEAT)) || !req_valid[r_owner]);
    assign w_next_base = (r_owner == c_LAST_IDX) ? '0 : r_owner + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= c_S_IDLE;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_beat_cnt <= w_beat_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_rr_nxt    = r_rr_ptr;
        w_beat_nxt  = r_beat_cnt;
        case (r_state)
            c_S_IDLE: begin
                if (|req_valid) begin
                    w_owner_nxt = rr_pick(r_rr_ptr, req_valid);
                    w_state_nxt = c_S_BURST;
                    w_beat_nxt  = '0;
                end
            end
            c_S_BURST: begin
                if (w_xfer) w_beat_nxt = r_beat_cnt + 1'b1;
                // Re-arbitrate on the ending edge so grants chain without a bubble.
                if (w_burst_end) begin
                    w_rr_nxt = w_next_base;
                    if (|req_valid) begin
                        w_owner_nxt = rr_pick(w_next_base, req_valid);
                        w_beat_nxt  = '0;
                    end else begin
                        w_state_nxt = c_S_IDLE;
                    end
                end
            end
            default: w_state_nxt = c_S_IDLE;
        endcase
    end

    always_comb begin
        fifo_w_en = w_xfer;
        req_ready = '0;
        if (w_xfer) req_ready[r_owner] = 1'b1;
        fifo_data_in = w_lane[r_owner];
    end

    assign busy     = (r_state == c_S_BURST);
    assign grant_id = r_owner;

`ifdef FIFO_ARB_STATS_EN
    logic [15:0] r_stat [NREQ];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREQ; i++) r_stat[i] <= '0;
        end else if (w_xfer && (r_stat[r_owner] != 16'hFFFF)) begin
            r_stat[r_owner] <= r_stat[r_owner] + 1'b1;
        end
    end

    assign stat_count = r_stat[stat_sel];
`endif

endmodule
`default_nettype wire
